// File: rtl/param_updown_counter_if.sv
// Bus bundle for param_updown_counter: control inputs, load/terminal values
// and the count/status outputs. The counter side uses the slave modport,
// whoever drives the counter uses the master modport.
interface param_updown_counter_if #(
  parameter int WIDTH = 8
);

  logic             sclr;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             ce;
  logic             up;
  logic [WIDTH-1:0] max;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
  logic             sat;

  modport master (
    output sclr,
    output load,
    output d,
    output ce,
    output up,
    output max,
    input  q,
    input  tc,
    input  wrap,
    input  sat
  );

  modport slave (
    input  sclr,
    input  load,
    input  d,
    input  ce,
    input  up,
    input  max,
    output q,
    output tc,
    output wrap,
    output sat
  );

endinterface

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with programmable terminal value, wrap or
// saturate behaviour, synchronous clear/load, count enable and a
// combinational carry-out (tc) intended to drive the ce of a following stage.
module param_updown_counter #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input logic                  clk,
  input logic                  clr,
  param_updown_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_next;
  logic             wrap_reg;
  logic             wrap_next;
  logic             sat_reg;
  logic             sat_next;
  logic             term;
  logic             counting;
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] count_dec;

  // Terminal condition: up direction treats anything at or above max as the
  // end of range (so a loaded value beyond max terminates on the next count),
  // down direction only terminates at zero.
  always_comb begin
    if (bus.up) begin
      term = (count >= bus.max);
    end else begin
      term = (count == ZERO);
    end
  end

  // A count cycle is one where ce is set and neither sclr nor load overrides it.
  always_comb begin
    counting = bus.ce & ~bus.sclr & ~bus.load;
  end

  assign count_inc = count + ONE;
  assign count_dec = count - ONE;

  // Next-state selection in priority order sclr > load > count > hold;
  // wrap is a pulse so it defaults low, sat holds unless q is changed.
  always_comb begin
    count_next = count;
    wrap_next  = 1'b0;
    sat_next   = sat_reg;
    if (bus.sclr) begin
      count_next = ZERO;
      sat_next   = 1'b0;
    end else if (bus.load) begin
      count_next = bus.d;
      sat_next   = 1'b0;
    end else if (bus.ce) begin
      if (!term) begin
        count_next = bus.up ? count_inc : count_dec;
        sat_next   = 1'b0;
      end else if (SATURATE) begin
        count_next = count;
        sat_next   = 1'b1;
      end else begin
        count_next = bus.up ? ZERO : bus.max;
        wrap_next  = 1'b1;
        sat_next   = 1'b0;
      end
    end
  end

  // State register; clr clears everything immediately, independent of clk.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count    <= ZERO;
      wrap_reg <= 1'b0;
      sat_reg  <= 1'b0;
    end else begin
      count    <= count_next;
      wrap_reg <= wrap_next;
      sat_reg  <= sat_next;
    end
  end

  assign bus.q    = count;
  assign bus.wrap = wrap_reg;
  assign bus.sat  = sat_reg;
  assign bus.tc   = counting & term;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed testbench for param_updown_counter: a wrap-mode instance, a
// saturate-mode instance and a two-stage cascade, checked through a
// scoreboard of expected register values popped after each clock edge.
module tb_param_updown_counter;

  localparam int U_WRAP = 0;
  localparam int U_SAT  = 1;
  localparam int U_LO   = 2;
  localparam int U_HI   = 3;

  typedef struct {
    int         unit;
    string      tag;
    logic [3:0] q;
    logic       wrap;
    logic       sat;
  } exp_t;

  logic clk;
  logic clr;
  int   checks;
  int   errors;
  int   hi_wrap_pulses;
  exp_t sb[$];

  int dn_q[4]    = '{1, 0, 9, 8};
  int dn_wrap[4] = '{0, 0, 1, 0};
  int dn_tc[4]   = '{0, 0, 1, 0};
  int st_q[5]    = '{4, 5, 5, 5, 5};
  int st_sat[5]  = '{0, 0, 1, 1, 1};
  int st_tc[5]   = '{0, 0, 1, 1, 1};

  param_updown_counter_if #(.WIDTH(4)) bus_w ();
  param_updown_counter_if #(.WIDTH(4)) bus_s ();
  param_updown_counter_if #(.WIDTH(4)) bus_l ();
  param_updown_counter_if #(.WIDTH(4)) bus_h ();

  param_updown_counter #(.WIDTH(4), .SATURATE(1'b0)) u_wrap (.clk(clk), .clr(clr), .bus(bus_w));
  param_updown_counter #(.WIDTH(4), .SATURATE(1'b1)) u_sat  (.clk(clk), .clr(clr), .bus(bus_s));
  param_updown_counter #(.WIDTH(4), .SATURATE(1'b0)) u_lo   (.clk(clk), .clr(clr), .bus(bus_l));
  param_updown_counter #(.WIDTH(4), .SATURATE(1'b0)) u_hi   (.clk(clk), .clr(clr), .bus(bus_h));

  assign bus_h.ce = bus_l.tc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      $error("[TB] FAIL %s", tag);
    end
  endtask

  function automatic logic [5:0] observe(input int unit);
    case (unit)
      U_WRAP:  return {bus_w.q, bus_w.wrap, bus_w.sat};
      U_SAT:   return {bus_s.q, bus_s.wrap, bus_s.sat};
      U_LO:    return {bus_l.q, bus_l.wrap, bus_l.sat};
      default: return {bus_h.q, bus_h.wrap, bus_h.sat};
    endcase
  endfunction

  task automatic push_exp(input int unit, input string tag, input logic [3:0] q, input logic wrap, input logic sat);
    exp_t e;
    e.unit = unit;
    e.tag  = tag;
    e.q    = q;
    e.wrap = wrap;
    e.sat  = sat;
    sb.push_back(e);
  endtask

  task automatic check_output();
    exp_t       e;
    logic [5:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.unit);
      check_val({e.tag, ".q"}, 32'(o[5:2]), 32'(e.q));
      check_val({e.tag, ".wrap"}, 32'(o[1]), 32'(e.wrap));
      check_val({e.tag, ".sat"}, 32'(o[0]), 32'(e.sat));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus_h.wrap === 1'b1) hi_wrap_pulses++;
    check_output();
  endtask

  task automatic apply_stimulus(input int unit, input logic sclr, input logic load, input logic [3:0] d,
                                input logic ce, input logic up, input logic [3:0] max);
    case (unit)
      U_WRAP: begin
        bus_w.sclr = sclr; bus_w.load = load; bus_w.d = d;
        bus_w.ce = ce; bus_w.up = up; bus_w.max = max;
      end
      U_SAT: begin
        bus_s.sclr = sclr; bus_s.load = load; bus_s.d = d;
        bus_s.ce = ce; bus_s.up = up; bus_s.max = max;
      end
      U_LO: begin
        bus_l.sclr = sclr; bus_l.load = load; bus_l.d = d;
        bus_l.ce = ce; bus_l.up = up; bus_l.max = max;
      end
      default: begin
        bus_h.sclr = sclr; bus_h.load = load; bus_h.d = d;
        bus_h.up = up; bus_h.max = max;
      end
    endcase
  endtask

  initial begin
    checks = 0;
    errors = 0;
    hi_wrap_pulses = 0;
    clr = 1'b1;
    apply_stimulus(U_WRAP, 0, 0, 4'd0, 0, 1, 4'd9);
    apply_stimulus(U_SAT,  0, 0, 4'd0, 0, 1, 4'd5);
    apply_stimulus(U_LO,   0, 0, 4'd0, 0, 1, 4'd15);
    apply_stimulus(U_HI,   0, 0, 4'd0, 0, 1, 4'd15);
    #2;
    $display("[TB] reset state");
    push_exp(U_WRAP, "reset_w", 4'd0, 0, 0);
    push_exp(U_SAT,  "reset_s", 4'd0, 0, 0);
    push_exp(U_LO,   "reset_l", 4'd0, 0, 0);
    push_exp(U_HI,   "reset_h", 4'd0, 0, 0);
    check_output();
    check_val("reset_tc_idle", 32'(bus_w.tc), 32'd0);
    apply_stimulus(U_WRAP, 0, 0, 4'd0, 1, 1, 4'd9);
    #1 check_val("reset_tc_up", 32'(bus_w.tc), 32'd0);
    apply_stimulus(U_WRAP, 0, 0, 4'd0, 1, 0, 4'd9);
    #1 check_val("reset_tc_down", 32'(bus_w.tc), 32'd1);
    apply_stimulus(U_WRAP, 0, 0, 4'd0, 0, 1, 4'd9);
    @(posedge clk);
    #1 clr = 1'b0;

    $display("[TB] wrap mode up 0..9");
    for (int k = 1; k <= 12; k++) begin
      apply_stimulus(U_WRAP, 0, 0, 4'd0, 1, 1, 4'd9);
      #1 check_val("up_tc", 32'(bus_w.tc), 32'(((k - 1) % 10) == 9));
      push_exp(U_WRAP, "up_count", 4'((k <= 9) ? k : k - 10), (k == 10), 1'b0);
      tick();
    end

    $display("[TB] wrap mode down through 0");
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(U_WRAP, 0, 0, 4'd0, 1, 0, 4'd9);
      #1 check_val("down_tc", 32'(bus_w.tc), 32'(dn_tc[k]));
      push_exp(U_WRAP, "down_count", 4'(dn_q[k]), dn_wrap[k][0], 1'b0);
      tick();
    end

    $display("[TB] load priority and q above max");
    apply_stimulus(U_WRAP, 0, 1, 4'd12, 1, 1, 4'd9);
    #1 check_val("load_tc", 32'(bus_w.tc), 32'd0);
    push_exp(U_WRAP, "load_12", 4'd12, 0, 0);
    tick();
    apply_stimulus(U_WRAP, 0, 0, 4'd0, 1, 1, 4'd9);
    #1 check_val("over_max_tc", 32'(bus_w.tc), 32'd1);
    push_exp(U_WRAP, "over_max_wrap", 4'd0, 1, 0);
    tick();
    apply_stimulus(U_WRAP, 0, 1, 4'd12, 0, 1, 4'd9);
    push_exp(U_WRAP, "load_12b", 4'd12, 0, 0);
    tick();
    apply_stimulus(U_WRAP, 0, 0, 4'd0, 1, 0, 4'd9);
    push_exp(U_WRAP, "over_max_down", 4'd11, 0, 0);
    tick();
    apply_stimulus(U_WRAP, 1, 1, 4'd7, 1, 1, 4'd9);
    #1 check_val("sclr_tc", 32'(bus_w.tc), 32'd0);
    push_exp(U_WRAP, "sclr_over_load", 4'd0, 0, 0);
    tick();

    $display("[TB] asynchronous clear mid-count");
    for (int k = 1; k <= 7; k++) begin
      apply_stimulus(U_WRAP, 0, 0, 4'd0, 1, 1, 4'd9);
      push_exp(U_WRAP, "pre_clr", 4'(k), 0, 0);
      tick();
    end
    #2 clr = 1'b1;
    #1;
    push_exp(U_WRAP, "clr_async", 4'd0, 0, 0);
    check_output();
    for (int k = 0; k < 3; k++) begin
      push_exp(U_WRAP, "clr_held", 4'd0, 0, 0);
      tick();
    end
    clr = 1'b0;
    push_exp(U_WRAP, "clr_resume", 4'd1, 0, 0);
    tick();

    $display("[TB] max zero and full range");
    for (int k = 0; k < 2; k++) begin
      apply_stimulus(U_WRAP, 0, 0, 4'd0, 1, 1, 4'd0);
      #1 check_val("max0_tc", 32'(bus_w.tc), 32'd1);
      push_exp(U_WRAP, "max0_wrap", 4'd0, 1, 0);
      tick();
    end
    apply_stimulus(U_WRAP, 0, 0, 4'd0, 1, 0, 4'd15);
    push_exp(U_WRAP, "full_down_wrap", 4'd15, 1, 0);
    tick();
    apply_stimulus(U_WRAP, 0, 0, 4'd0, 1, 1, 4'd15);
    push_exp(U_WRAP, "full_up_wrap", 4'd0, 1, 0);
    tick();
    apply_stimulus(U_WRAP, 0, 0, 4'd0, 0, 1, 4'd15);
    #1 check_val("idle_tc", 32'(bus_w.tc), 32'd0);
    push_exp(U_WRAP, "idle_hold", 4'd0, 0, 0);
    tick();

    $display("[TB] saturate mode");
    apply_stimulus(U_SAT, 0, 1, 4'd3, 0, 1, 4'd5);
    push_exp(U_SAT, "sat_load3", 4'd3, 0, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(U_SAT, 0, 0, 4'd0, 1, 1, 4'd5);
      #1 check_val("sat_tc", 32'(bus_s.tc), 32'(st_tc[k]));
      push_exp(U_SAT, "sat_up", 4'(st_q[k]), 0, st_sat[k][0]);
      tick();
    end
    apply_stimulus(U_SAT, 0, 0, 4'd0, 0, 1, 4'd5);
    push_exp(U_SAT, "sat_idle_hold", 4'd5, 0, 1);
    tick();
    apply_stimulus(U_SAT, 0, 0, 4'd0, 1, 0, 4'd5);
    push_exp(U_SAT, "sat_down", 4'd4, 0, 0);
    tick();
    apply_stimulus(U_SAT, 0, 1, 4'd0, 0, 1, 4'd0);
    push_exp(U_SAT, "sat_load0", 4'd0, 0, 0);
    tick();
    apply_stimulus(U_SAT, 0, 0, 4'd0, 1, 1, 4'd0);
    push_exp(U_SAT, "sat_max0", 4'd0, 0, 1);
    tick();
    apply_stimulus(U_SAT, 0, 1, 4'd2, 1, 1, 4'd0);
    push_exp(U_SAT, "sat_load_clears", 4'd2, 0, 0);
    tick();
    apply_stimulus(U_SAT, 0, 0, 4'd0, 0, 1, 4'd5);

    $display("[TB] two-stage cascade");
    hi_wrap_pulses = 0;
    for (int k = 1; k <= 256; k++) begin
      apply_stimulus(U_LO, 0, 0, 4'd0, 1, 1, 4'd15);
      push_exp(U_LO, "cas_lo", 4'(k % 16), ((k % 16) == 0), 1'b0);
      push_exp(U_HI, "cas_hi", 4'((k / 16) % 16), (k == 256), 1'b0);
      tick();
    end
    apply_stimulus(U_LO, 0, 0, 4'd0, 0, 1, 4'd15);
    check_val("cas_hi_wrap_count", 32'(hi_wrap_pulses), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
